// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit and receive paths: the frame
// state encoding, frame geometry constants and the parity helper that both
// the transmitter and the receive-side checker use.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   // Even parity is the XOR of all bits; odd parity is its inverse.
   function automatic logic uart_parity(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Counts clocks within one serial bit and flags the last clock of the bit.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : forces the counter back to 0 (frame acceptance)
//   run        : counter advances only while a frame is in progress
//   bit_end    : high on the final clock of the current bit
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic bit_end
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Wrap to 0 at each bit end so every bit lasts exactly CLKS_PER_BIT clocks.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter: accepts one byte over a valid/ready handshake and sends
// an 11-bit frame (start, 8 data bits LSB first, parity, stop) on tx.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   tx_data    : byte to send, sampled only when accepted
//   tx_valid   : source has a byte
//   tx_ready   : block can accept (IDLE only)
//   tx         : registered serial line, idles high
//   tx_busy    : frame in progress
//   tx_done    : one-clock pulse after the stop bit completes
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [2:0]           idx_q, idx_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 tx_done_q, tx_done_d;
   logic                 accept;
   logic                 bit_end;

   assign tx_ready = (state_q == ST_IDLE);
   assign tx_busy  = ~tx_ready;
   assign accept   = tx_valid && tx_ready;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .run    (tx_busy),
      .bit_end(bit_end)
   );

   // tx is registered, so its next value is decoded from the next state;
   // that way the line changes on the same edge the state does.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      idx_d     = idx_q;
      parity_d  = parity_q;
      tx_done_d = 1'b0;
      tx_d      = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_START;
               shreg_d  = tx_data;
               parity_d = uart_parity(tx_data, PARITY_ODD);
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d   = ST_IDLE;
               tx_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = parity_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         idx_q     <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         idx_q     <= idx_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = tx_done_q;

endmodule
